exception_vector_fetch: RTL
===========================

EXCEPTION_VECTOR_FETCH -- requirements
Module: exception_vector_fetch

Interface
REQ-001 Parameter VEC_BASE, default 32'd253, byte address of the first exception vector.
REQ-002 Parameter MEM_LATENCY, default 1, memory read latency in cycles (legal range 1..7).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 exc_opcode  input  1  invalid-opcode exception request.
REQ-006 exc_overflow  input  1  arithmetic overflow exception request.
REQ-007 exc_div0  input  1  divide-by-zero exception request.
REQ-008 pc_in  input  32  current PC (already incremented by 4).
REQ-009 mem_data_in  input  32  memory read data; bits [7:0] hold the vector byte.
REQ-010 mem_addr  output  32  memory read address.
REQ-011 mem_rd  output  1  memory read strobe.
REQ-012 memory_byte  output  8  captured vector byte, fed to the 16-to-32 extender's 8-bit input.
REQ-013 control_bit  output  1  extender select; 1 selects the zero-extended byte.
REQ-014 epc_out  output  32  exception PC value.
REQ-015 epc_wr  output  1  EPC register write enable.
REQ-016 pc_wr  output  1  PC write enable (loads the extender output into PC).
REQ-017 exc_code  output  2  latched cause: 0 opcode, 1 overflow, 2 div0, 3 never produced.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, JUMP; exactly one active at a time.
REQ-020 IDLE: if any exc_* input is high at a rising edge, latch the cause and pc_in, then go to REQ; otherwise stay in IDLE.
REQ-021 Simultaneous requests SHALL resolve by priority opcode > overflow > div0; lower-priority requests are dropped, not queued.
REQ-022 exc_* inputs SHALL be ignored whenever busy=1.
REQ-023 REQ (1 cycle): mem_rd=1; mem_addr=VEC_BASE+exc_code (253/254/255 with the defaults); epc_wr=1; epc_out=latched pc_in-4 (32-bit wrap-around; pc_in=0 gives 32'hFFFFFFFC).
REQ-024 WAIT SHALL last exactly MEM_LATENCY cycles, counted by an internal counter that loads on REQ exit. mem_rd=0 and mem_addr holds its value throughout.
REQ-025 On the rising edge that ends WAIT, memory_byte SHALL capture mem_data_in[7:0]; bits [31:8] are ignored.
REQ-026 JUMP (1 cycle): control_bit=1, pc_wr=1, memory_byte stable; next state IDLE.
REQ-027 control_bit SHALL be 0 in IDLE, REQ and WAIT, so the extender passes the immediate path during normal execution.
REQ-028 Latency from the sampling edge in IDLE to pc_wr high SHALL be 1+MEM_LATENCY cycles; one full sequence occupies 2+MEM_LATENCY cycles.
REQ-029 memory_byte, epc_out and exc_code SHALL hold their last values in IDLE until the next exception.
REQ-030 A request still high in the cycle after JUMP (IDLE) SHALL start a new sequence.
REQ-031 epc_wr, pc_wr and mem_rd SHALL each be single-cycle pulses per sequence.

Reset
REQ-032 While reset=0, state=IDLE and counter=0, independent of clk.
REQ-033 While reset=0, all outputs SHALL be 0: mem_addr, mem_rd, memory_byte, control_bit, epc_out, epc_wr, pc_wr, exc_code, busy.
REQ-034 Reset asserted in the middle of a sequence SHALL abort it with no further pc_wr or epc_wr.
REQ-035 After reset release, the first rising edge SHALL sample exc_* normally.

Verification
REQ-036 Opcode exception: pc_in=0x00000108, exc_opcode pulse, mem_data_in=0x000000A5, MEM_LATENCY=1 -> REQ with mem_addr=253, epc_out=0x104, epc_wr=1; next cycle WAIT; then JUMP with memory_byte=0xA5, control_bit=1, pc_wr=1; then IDLE.
REQ-037 Simultaneous requests: exc_overflow=exc_div0=1 -> exc_code=1, mem_addr=254, exactly one sequence.
REQ-038 MEM_LATENCY=3, exc_div0 -> mem_addr=255; pc_wr asserts 4 cycles after the sampling edge; mem_data_in[31:8]=0xFFFFFF does not affect memory_byte.
REQ-039 Busy masking: exc_opcode raised during WAIT of an overflow sequence -> ignored; exc_code stays 1.
REQ-040 Reset mid-WAIT: reset=0 -> all outputs 0 immediately; no pc_wr after release.
REQ-041 Wrap-around: pc_in=0x00000000 -> epc_out=0xFFFFFFFC.

Source files
------------

// File: rtl/exception_vector_fetch.sv
// Exception vector fetch sequencer: latches an exception cause, reads the vector
// byte from memory, writes EPC and then steers the PC extender to the vector.
module exception_vector_fetch #(
    parameter logic [31:0] VEC_BASE    = 32'd253,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [7:0]  memory_byte,
    output logic        control_bit,
    output logic [31:0] epc_out,
    output logic        epc_wr,
    output logic        pc_wr,
    output logic [1:0]  exc_code,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_JUMP
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       any_exc;
    logic [1:0] cause;
    logic       wait_done;
    logic       unused_data;

    assign unused_data = ^mem_data_in[31:8];
    assign any_exc     = exc_opcode | exc_overflow | exc_div0;
    // Fixed priority; lower-priority simultaneous requests are simply dropped.
    assign cause       = exc_opcode ? 2'd0 : (exc_overflow ? 2'd1 : 2'd2);
    assign wait_done   = (state == S_WAIT) && (cnt == 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_rd      = 1'b0;
        epc_wr      = 1'b0;
        pc_wr       = 1'b0;
        control_bit = 1'b0;
        busy        = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (any_exc) state_nxt = S_REQ;
            end
            S_REQ: begin
                mem_rd    = 1'b1;
                epc_wr    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done) state_nxt = S_JUMP;
            end
            S_JUMP: begin
                control_bit = 1'b1;
                pc_wr       = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter preloads on REQ exit so WAIT spans exactly MEM_LATENCY cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == S_REQ) begin
            cnt <= CNT_LOAD;
        end else if (state == S_WAIT && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr    <= '0;
            epc_out     <= '0;
            exc_code    <= '0;
            memory_byte <= '0;
        end else begin
            if (state == S_IDLE && any_exc) begin
                exc_code <= cause;
                mem_addr <= VEC_BASE + {30'd0, cause};
                epc_out  <= pc_in - 32'd4;
            end
            if (wait_done) begin
                memory_byte <= mem_data_in[7:0];
            end
        end
    end

endmodule
